// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Build option: FETCH_HALT_DETECT_EN turns the HALT word into an early stop.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  localparam logic [14:0] NOP_WORD  = 15'h0000;
  localparam logic [14:0] HALT_WORD = 15'h7FFF;

  function automatic logic is_busy(state_t s);
    return (s == FETCH) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter for the fetch unit: clear beats increment, else hold.
// Synchronous active-high reset.
module pc_counter #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: streams prog_len ROM words, then drains NOPs.
// Build option: FETCH_HALT_DETECT_EN stops fetch early on the HALT word.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int ADDR_W       = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] prog_len,
  input  logic              stall,
  output logic [ADDR_W-1:0] address_imem,
  input  logic [14:0]       rom_data,
  output logic [14:0]       q_imem,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W =
    (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] len_nx;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_nx;
  logic [14:0]       q_q;
  logic [14:0]       q_nx;
  logic              pc_clr;
  logic              pc_inc;
  logic              is_halt;
  logic              last;
  logic              to_drain;

  pc_counter #(
    .ADDR_W(ADDR_W)
  ) u_pc (
    .clock(clock),
    .reset(reset),
    .clr  (pc_clr),
    .inc  (pc_inc),
    .pc   (pc)
  );

`ifdef FETCH_HALT_DETECT_EN
  assign is_halt = (rom_data == HALT_WORD);
`else
  assign is_halt = 1'b0;
`endif

  // len_q is never 0 while fetching, so len_q-1 cannot wrap.
  assign last = (pc == (len_q - ADDR_W'(1)));

  always_comb begin
    state_nx = state;
    len_nx   = len_q;
    cnt_nx   = cnt_q;
    q_nx     = q_q;
    pc_clr   = 1'b0;
    pc_inc   = 1'b0;
    to_drain = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        q_nx = NOP_WORD;
        if (start && (prog_len != '0)) begin
          state_nx = FETCH;
          pc_clr   = 1'b1;
          len_nx   = prog_len;
        end
      end
      FETCH: begin
        if (!stall) begin
          if (is_halt) begin
            q_nx     = NOP_WORD;
            to_drain = 1'b1;
          end else begin
            q_nx = rom_data;
            if (last) begin
              to_drain = 1'b1;
            end else begin
              pc_inc = 1'b1;
            end
          end
        end
        if (to_drain) begin
          cnt_nx   = CNT_W'(DRAIN_CYCLES);
          state_nx = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (!stall) begin
          q_nx   = NOP_WORD;
          cnt_nx = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            cnt_nx   = '0;
            state_nx = DONE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
      q_q   <= NOP_WORD;
    end else begin
      state <= state_nx;
      len_q <= len_nx;
      cnt_q <= cnt_nx;
      q_q   <= q_nx;
    end
  end

  assign address_imem = pc;
  assign q_imem       = q_q;
  assign busy         = is_busy(state);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: stream model plus directed literals.
// Honours FETCH_HALT_DETECT_EN the same way the design does.
module tb_fetch_unit;

  localparam int DC = 3;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] prog_len = '0;
  logic          stall = 1'b0;
  logic [AW-1:0] address_imem;
  logic [14:0]   rom_data;
  logic [14:0]   q_imem;
  logic          busy;
  logic          done;

  logic [14:0] rom [256];

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  assign rom_data = rom[address_imem];

  fetch_unit #(
    .DRAIN_CYCLES(DC),
    .ADDR_W      (AW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .prog_len    (prog_len),
    .stall       (stall),
    .address_imem(address_imem),
    .rom_data    (rom_data),
    .q_imem      (q_imem),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // A run is a stream of words: fetched ROM words (cut at a HALT when
  // halt detection is built in), then DC NOPs; stall just pauses it.
  function automatic int fetch_count(int len);
    for (int k = 0; k < len; k++) begin
`ifdef FETCH_HALT_DETECT_EN
      if (rom[8'(k)] == 15'h7FFF) return k + 1;
`endif
    end
    return len;
  endfunction

  function automatic int stream(int k, int fc);
    if (k < 0 || k >= fc) return 0;
`ifdef FETCH_HALT_DETECT_EN
    if (rom[8'(k)] == 15'h7FFF) return 0;
`endif
    return int'(rom[8'(k)]);
  endfunction

  bit m_act;
  bit m_fin;
  int m_idx;
  int m_fc;

  always @(posedge clock) begin
    if (reset) begin
      m_act <= 1'b0;
      m_fin <= 1'b0;
      m_idx <= 0;
      m_fc  <= 0;
    end else if (!m_act) begin
      if (start && prog_len != 0) begin
        m_act <= 1'b1;
        m_fin <= 1'b0;
        m_idx <= 0;
        m_fc  <= fetch_count(int'(prog_len));
      end
    end else if (!stall) begin
      m_idx <= m_idx + 1;
      if (m_idx + 1 == m_fc + DC) begin
        m_act <= 1'b0;
        m_fin <= 1'b1;
      end
    end
  end

  function automatic int exp_addr();
    if (m_idx == 0) return 0;
    return (m_idx < m_fc - 1) ? m_idx : m_fc - 1;
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_q", int'(q_imem), stream(m_idx - 1, m_fc));
      check("model_addr", int'(address_imem), exp_addr());
      check("model_busy", int'(busy), int'(m_act));
      check("model_done", int'(done), int'(m_fin));
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic pulse_start(int len);
    start    = 1'b1;
    prog_len = AW'(len);
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(int maxc, string name);
    int n = 0;
    while (!done && n < maxc) begin
      tick();
      n++;
    end
    check(name, int'(done), 1);
  endtask

  initial begin
    logic [14:0] lit_q [8];
    lit_q = '{15'h0, 15'h0A00, 15'h0A01, 15'h0A02,
              15'h0A03, 15'h0, 15'h0, 15'h0};
    for (int i = 0; i < 256; i++) rom[i] = 15'h0A00 + 15'(i);

    tick();
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_q", int'(q_imem), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(address_imem), 0);

    // Scenario 1: four words then three NOPs
    pulse_start(4);
    check("s1_q0", int'(q_imem), int'(lit_q[0]));
    check("s1_busy", int'(busy), 1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("s1_q%0d", i), int'(q_imem), int'(lit_q[i]));
      if (i == 6) check("s1_not_done", int'(done), 0);
    end
    check("s1_done", int'(done), 1);
    check("s1_addr_hold", int'(address_imem), 3);

    // Scenario 6 + 2: rerun from DONE, stall while PC=1
    pulse_start(4);
    check("s6_done_clr", int'(done), 0);
    check("s6_pc0", int'(address_imem), 0);
    tick();
    check("s2_pc1", int'(address_imem), 1);
    stall = 1'b1;
    tick();
    tick();
    check("s2_hold_pc", int'(address_imem), 1);
    check("s2_hold_q", int'(q_imem), 15'h0A00);
    stall = 1'b0;
    tick();
    check("s2_resume_q", int'(q_imem), 15'h0A01);
    tick();
    tick();
    stall = 1'b1;
    tick();
    stall = 1'b0;
    wait_done(20, "s2_done");

    // Scenario 3: zero length, then start while busy
    pulse_start(0);
    check("s3_len0_done", int'(done), 1);
    check("s3_len0_busy", int'(busy), 0);
    pulse_start(5);
    tick();
    pulse_start(2);
    check("s3_busy_pc", int'(address_imem), 2);
    wait_done(20, "s3_done");
    check("s3_last_pc", int'(address_imem), 4);

    // Scenario 4: reset in DRAIN with two counts left
    pulse_start(4);
    for (int i = 0; i < 5; i++) tick();
    check("s4_in_drain", int'(busy), 1);
    reset = 1'b1;
    start = 1'b1;
    prog_len = AW'(3);
    stall = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    check("s4_q", int'(q_imem), 0);
    check("s4_busy", int'(busy), 0);
    check("s4_done", int'(done), 0);
    check("s4_addr", int'(address_imem), 0);

    // Scenario 5: HALT word at address 2
    rom[2] = 15'h7FFF;
    pulse_start(6);
    tick();
    check("s5_q0", int'(q_imem), 15'h0A00);
    tick();
    check("s5_q1", int'(q_imem), 15'h0A01);
    tick();
`ifdef FETCH_HALT_DETECT_EN
    check("s5_q2", int'(q_imem), 0);
    tick();
    tick();
    tick();
    check("s5_done", int'(done), 1);
`else
    check("s5_q2", int'(q_imem), 15'h7FFF);
    tick();
    tick();
    tick();
    check("s5_q5", int'(q_imem), 15'h0A05);
    tick();
    tick();
    tick();
    check("s5_done", int'(done), 1);
`endif
    wait_done(20, "s5_done_wait");
    rom[2] = 15'h0A02;

    // Longest program with sporadic stalls
    start = 1'b1;
    prog_len = AW'(255);
    tick();
    start = 1'b0;
    for (int n = 0; n < 600 && !done; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      tick();
    end
    stall = 1'b0;
    check("max_done", int'(done), 1);
    check("max_last_pc", int'(address_imem), 254);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
